// File: rtl/sr_math_arb.sv
// sr_math_arb: round-robin arbiter sharing one start/busy math unit among N_REQ requesters.
// Define SR_MATH_ARB_TIMEOUT_EN to build the watchdog that aborts a hung math-unit operation.
module sr_math_arb #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [32*N_REQ-1:0]      req_a_i,
  input  logic [32*N_REQ-1:0]      req_b_i,
  output logic [N_REQ-1:0]         rsp_valid_o,
  input  logic [N_REQ-1:0]         rsp_ready_i,
  output logic [RES_W-1:0]         rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     fu_start_o,
  output logic [31:0]              fu_a_o,
  output logic [31:0]              fu_b_o,
  input  logic [RES_W-1:0]         fu_y_i,
  input  logic                     fu_busy_i,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     busy_o
);
  localparam int unsigned GW = $clog2(N_REQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_d;
  logic              fu_start_d;
  logic [31:0]       fu_a_d, fu_b_d;
  logic [N_REQ-1:0]  rsp_valid_d;
  logic [RES_W-1:0]  rsp_data_d;
  logic              rsp_err_d;
  logic              win_found;
  logic [GW-1:0]     win_idx;
  int unsigned       scan_idx;
  int unsigned       op_base;
  logic              wd_hit;

`ifdef SR_MATH_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] wd_q, wd_d;
  assign wd_hit = (wd_q == CW'(TIMEOUT));
`else
  assign wd_hit = 1'b0;
`endif

  // Winner: first valid requester after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!win_found && req_valid_i[GW'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = GW'(scan_idx);
      end
    end
  end

  // Ready only to the winner, and never while the math unit is still busy
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && win_found && !fu_busy_i) begin
      req_ready_o[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_o;
    fu_start_d  = 1'b0;
    fu_a_d      = fu_a_o;
    fu_b_d      = fu_b_o;
    rsp_valid_d = rsp_valid_o;
    rsp_data_d  = rsp_data_o;
    rsp_err_d   = rsp_err_o;
    op_base     = 32'(win_idx) << 5;
`ifdef SR_MATH_ARB_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_ready_o) begin
          state_d    = ISSUE;
          grant_d    = win_idx;
          fu_a_d     = req_a_i[op_base +: 32];
          fu_b_d     = req_b_i[op_base +: 32];
          fu_start_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
`ifdef SR_MATH_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      WAIT_HI, WAIT_LO: begin
`ifdef SR_MATH_ARB_TIMEOUT_EN
        wd_d = wd_q + CW'(1);
`endif
        if (state_q == WAIT_HI && fu_busy_i) begin
          state_d = WAIT_LO;
        end else if (state_q == WAIT_LO && !fu_busy_i) begin
          state_d     = RESP;
          rsp_valid_d = N_REQ'(1) << grant_o;
          rsp_data_d  = fu_y_i;
          rsp_err_d   = 1'b0;
          fu_a_d      = '0;
          fu_b_d      = '0;
        end else if (wd_hit) begin
          // Watchdog abort: report all-ones with the error flag
          state_d     = RESP;
          rsp_valid_d = N_REQ'(1) << grant_o;
          rsp_data_d  = '1;
          rsp_err_d   = 1'b1;
          fu_a_d      = '0;
          fu_b_d      = '0;
        end
      end
      RESP: begin
        if (rsp_ready_i[grant_o]) begin
          state_d     = IDLE;
          rr_ptr_d    = grant_o;
          rsp_valid_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= GW'(N_REQ - 1);
      grant_o     <= '0;
      fu_start_o  <= 1'b0;
      fu_a_o      <= '0;
      fu_b_o      <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
`ifdef SR_MATH_ARB_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_o     <= grant_d;
      fu_start_o  <= fu_start_d;
      fu_a_o      <= fu_a_d;
      fu_b_o      <= fu_b_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o  <= rsp_data_d;
      rsp_err_o   <= rsp_err_d;
      busy_o      <= (state_d != IDLE);
`ifdef SR_MATH_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_sr_math_arb.sv
// tb_sr_math_arb: directed + randomized bench for sr_math_arb with a behavioural math unit
// (busy for busy_len cycles, result = (a+b) low 16 bits) and a round-robin reference model.
module tb_sr_math_arb;
  localparam int unsigned N  = 2;
  localparam int unsigned RW = 16;
  localparam int unsigned TO = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [RW-1:0]   rsp_data;
  logic            rsp_err;
  logic            fu_start;
  logic [31:0]     fu_a, fu_b;
  logic [RW-1:0]   fu_y = '0;
  logic            fu_busy = 1'b0;
  logic [0:0]      grant;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int busy_len = 5;
  int rr_last = N - 1;
  int obs_served[N];

  sr_math_arb #(.N_REQ(N), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .fu_start_o(fu_start), .fu_a_o(fu_a), .fu_b_o(fu_b),
    .fu_y_i(fu_y), .fu_busy_i(fu_busy),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fu_start === 1'b1) starts <= starts + 1;

  // Math unit: sees start in one cycle, is busy for busy_len cycles starting the next
  initial begin
    logic st, r;
    logic [31:0] sum;
    int left;
    left = 0;
    forever begin
      @(negedge clk);
      st  = fu_start;
      r   = rst;
      sum = fu_a + fu_b;
      @(posedge clk); #1;
      if (r) begin
        fu_busy = 1'b0;
        left = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) fu_busy = 1'b0;
      end else if (st === 1'b1 && busy_len > 0) begin
        fu_busy = 1'b1;
        fu_y    = sum[RW-1:0];
        left    = busy_len;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
    check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    check({tag, "_fu_start"},  64'(fu_start),  64'd0);
    check({tag, "_fu_a"},      64'(fu_a),      64'd0);
    check({tag, "_fu_b"},      64'(fu_b),      64'd0);
    check({tag, "_grant"},     64'(grant),     64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  // One full transaction; called just after a rising edge. blen==0 means busy never rises.
  task automatic run_txn(input logic [N-1:0] mask, input int blen, input int bp);
    int w, hs, lat, s0;
    logic got, stray, stable;
    logic [N-1:0] oh;
    logic [31:0] ea, eb, sum;
    logic [RW-1:0] exp_d;
    busy_len  = blen;
    req_valid = req_valid | mask;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && req_valid[(rr_last + k) % N]) w = (rr_last + k) % N;
    oh = '0;
    oh[w] = 1'b1;
    rsp_ready = (bp > 0) ? ~oh : '1;
    s0 = starts;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    check("req_ready_seen", 64'(got), 64'd1);
    if (!got) return;
    check("ready_winner", 64'(req_ready), 64'(oh));
    hs  = cyc;
    ea  = req_a[32*w +: 32];
    eb  = req_b[32*w +: 32];
    sum = ea + eb;
    exp_d = (blen == 0) ? '1 : sum[RW-1:0];
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    got = 1'b0;
    stray = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid != '0) got = 1'b1;
      else if (req_ready != '0) stray = 1'b1;
    end
    check("rsp_valid_seen", 64'(got), 64'd1);
    if (!got) return;
    lat = cyc - hs;
    if (blen > 0) check("latency", 64'(lat), 64'(3 + blen));
    else          check("timeout_latency_ge", 64'(lat >= TO), 64'd1);
    check("no_ready_while_busy", 64'(stray), 64'd0);
    check("rsp_valid_onehot", 64'(rsp_valid), 64'(oh));
    check("rsp_data", 64'(rsp_data), 64'(exp_d));
    check("rsp_err", 64'(rsp_err), 64'(blen == 0));
    check("grant", 64'(grant), 64'(w));
    for (int i = 0; i < N; i++) if (rsp_valid[i]) obs_served[i]++;
    if (bp > 0) begin
      stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (rsp_valid !== oh || rsp_data !== exp_d || req_ready !== '0) stable = 1'b0;
      end
      check("backpressure_stable", 64'(stable), 64'd1);
      @(posedge clk); #1;
      rsp_ready = '1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = '0;
    check("rsp_valid_dropped", 64'(rsp_valid), 64'd0);
    check("rsp_data_held", 64'(rsp_data), 64'(exp_d));
    check("start_pulses", 64'(starts - s0), 64'd1);
    rr_last = w;
  endtask

  initial begin
    logic got;
    for (int i = 0; i < N; i++) obs_served[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single request from requester 0
    req_a[31:0] = 32'h0000_1234;
    req_b[31:0] = 32'h0000_0010;
    run_txn(2'b01, 5, 0);
    check("single_data_1244", 64'(rsp_data), 64'h1244);

    // One-cycle busy from requester 1
    req_a[63:32] = 32'd7;
    req_b[63:32] = 32'd9;
    run_txn(2'b10, 1, 0);
    check("onecycle_data_0010", 64'(rsp_data), 64'h0010);

    // Reset while in WAIT_LO; requester 1 wins from rr_last=1 -> 0 invalid, 1 valid
    busy_len = 6;
    req_valid = 2'b10;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    check("rst_test_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (fu_busy) got = 1'b1;
    end
    check("rst_test_busy_seen", 64'(got), 64'd1);
    @(negedge clk);
    check("rst_test_grant_before", 64'(grant), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("midreset");
    rr_last = N - 1;

    // Round-robin after reset with both requesters valid
    for (int i = 0; i < N; i++) obs_served[i] = 0;
    for (int i = 0; i < 4; i++) begin
      req_a[32*(i%2) +: 32] = $urandom;
      req_b[32*(i%2) +: 32] = $urandom;
      run_txn(2'b11, 2 + i, 0);
      check("rr_order", 64'(grant), 64'(i % 2));
    end
    check("rr_served0", 64'(obs_served[0]), 64'd2);
    check("rr_served1", 64'(obs_served[1]), 64'd2);

    // Response backpressure with the other requester pending
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    run_txn(2'b11, 3, 10);
    run_txn(2'b00, 2, 0);

    // Randomized traffic
    for (int i = 0; i < 10; i++) begin
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      run_txn(N'($urandom_range(1, 3)), $urandom_range(1, 6), $urandom_range(0, 3));
    end
    req_valid = '0;

`ifdef SR_MATH_ARB_TIMEOUT_EN
    // Math unit never answers: watchdog abort, then a normal transaction
    req_a[31:0] = $urandom;
    req_b[31:0] = $urandom;
    run_txn(2'b01, 0, 0);
    req_a[31:0] = 32'd100;
    req_b[31:0] = 32'd23;
    run_txn(2'b01, 4, 0);
    check("after_timeout_data", 64'(rsp_data), 64'd123);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
